// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared lane geometry, mode encodings and FSM states for the MAC result unpacker
package mac_pkg;

  localparam int LANE32_W = 32;
  localparam int LANE16_W = 16;
  localparam int NLANE32  = 4;
  localparam int NLANE16  = 8;
  localparam int DATA_W   = 4 * LANE32_W;
  localparam int OUT_W    = 32;

  localparam logic MODE_32 = 1'b1;
  localparam logic MODE_16 = 1'b0;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

endpackage

// File: rtl/mac_result_unpacker_if.sv
// rtl/mac_result_unpacker_if.sv - packed-word input and lane-beat output streams of the unpacker
interface mac_result_unpacker_if;
  import mac_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic [2:0]        out_idx;
  logic              out_last;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/mac_lane_select.sv
// rtl/mac_lane_select.sv - picks one lane of a packed word and widens it to 32 bits
// MAC_UNPACK_SIGN_EXT_EN selects sign extension of 16-bit lanes (default zero extension).
module mac_lane_select
  import mac_pkg::*;
(
  input  logic [DATA_W-1:0] hold,
  input  logic              mode,
  input  logic [2:0]        idx,
  output logic [OUT_W-1:0]  lane,
  output logic              last
);

  logic [DATA_W-1:0]   sh32;
  logic [DATA_W-1:0]   sh16;
  logic [LANE16_W-1:0] half;

  assign sh32 = hold >> {idx[1:0], 5'b0};
  assign sh16 = hold >> {idx, 4'b0};
  assign half = sh16[LANE16_W-1:0];

  always_comb begin
    lane = '0;
    last = 1'b0;
    if (mode == MODE_32) begin
      lane = sh32[LANE32_W-1:0];
      last = (idx[1:0] == 2'(NLANE32 - 1));
    end else begin
`ifdef MAC_UNPACK_SIGN_EXT_EN
      lane = {{(OUT_W - LANE16_W){half[LANE16_W-1]}}, half};
`else
      lane = {{(OUT_W - LANE16_W){1'b0}}, half};
`endif
      last = (idx == 3'(NLANE16 - 1));
    end
  end

  logic unused_idx2;
  assign unused_idx2 = idx[2] & (mode == MODE_32);

endmodule

// File: rtl/mac_result_unpacker.sv
// rtl/mac_result_unpacker.sv - serialises a 128-bit packed sum word into 32-bit lane beats
// Build option MAC_UNPACK_SIGN_EXT_EN sign-extends 16-bit lanes.
module mac_result_unpacker
  import mac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  mac_result_unpacker_if.slave  bus
);

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] hold;
  logic              hold_mode;
  logic              handshake;
  logic              load_first;
  logic              load_next;
  logic              drop;
  logic [OUT_W-1:0]  first_lane;
  logic [OUT_W-1:0]  next_lane;
  logic              first_last;
  logic              next_last;
  logic [2:0]        next_idx;

  assign handshake   = bus.out_valid && bus.out_ready;
  assign next_idx    = bus.out_idx + 3'd1;
  assign bus.in_ready = (state == IDLE) || (handshake && bus.out_last);

  // Lane 0 comes straight from the incoming word so the first beat is ready one cycle after accept.
  mac_lane_select u_first (
    .hold (bus.in_data),
    .mode (bus.in_mode),
    .idx  (3'd0),
    .lane (first_lane),
    .last (first_last)
  );

  mac_lane_select u_next (
    .hold (hold),
    .mode (hold_mode),
    .idx  (next_idx),
    .lane (next_lane),
    .last (next_last)
  );

  always_comb begin
    state_n    = state;
    load_first = 1'b0;
    load_next  = 1'b0;
    drop       = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          load_first = 1'b1;
          state_n    = DRAIN;
        end
      end
      DRAIN: begin
        if (handshake) begin
          if (!bus.out_last) begin
            load_next = 1'b1;
          end else if (bus.in_valid) begin
            load_first = 1'b1;
          end else begin
            drop    = 1'b1;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      hold          <= '0;
      hold_mode     <= MODE_32;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_idx   <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      state <= state_n;
      if (load_first) begin
        hold          <= bus.in_data;
        hold_mode     <= bus.in_mode;
        bus.out_valid <= 1'b1;
        bus.out_data  <= first_lane;
        bus.out_idx   <= 3'd0;
        bus.out_last  <= first_last;
      end else if (load_next) begin
        bus.out_data <= next_lane;
        bus.out_idx  <= next_idx;
        bus.out_last <= next_last;
      end else if (drop) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end

endmodule
